// File: rtl/vga_column_scheduler_if.sv
// Sample-source handshake and VGA pixel-write bus for vga_column_scheduler.
// master = scheduler side, slave = sample source / VGA adapter side.
interface vga_column_scheduler_if;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready;
  logic [8:0]  x_coords;
  logic [7:0]  y_coords;
  logic [2:0]  color_on_vga;
  logic        plot_on_vga;
  logic        frame_done;

  modport master (
    input  sample_valid, sample_data,
    output sample_ready, x_coords, y_coords, color_on_vga, plot_on_vga, frame_done
  );

  modport slave (
    output sample_valid, sample_data,
    input  sample_ready, x_coords, y_coords, color_on_vga, plot_on_vga, frame_done
  );
endinterface

// File: rtl/vga_column_scheduler.sv
// Column sequencer for the audio visualizer: accept a sample, erase the column, plot the trace.
// Optional TRACE_CONNECT_EN: draw a vertical run joining the previous column's trace row.
module vga_column_scheduler #(
  parameter int unsigned X_MAX       = 319,
  parameter int unsigned Y_MAX       = 239,
  parameter int unsigned Y_MID       = 120,
  parameter int unsigned HOLD_CYCLES = 5000,
  parameter logic [2:0]  COLOR_BG    = 3'b000,
  parameter logic [2:0]  COLOR_FG    = 3'b010
) (
  input  logic clock,
  input  logic reset,
  input  logic pause,
  vga_column_scheduler_if.master bus
);

  localparam int unsigned       DW     = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0]     HOLD   = DW'(HOLD_CYCLES);
  localparam logic [8:0]        XM     = 9'(X_MAX);
  localparam logic [7:0]        YM     = 8'(Y_MAX);
  localparam logic signed [9:0] YMID_S = 10'(Y_MID);
  localparam logic signed [9:0] YMAX_S = 10'(Y_MAX);

  typedef enum logic [1:0] {S_WAIT, S_CLEAR, S_DRAW, S_ADVANCE} state_t;

  state_t        r_state;
  logic [DW-1:0] r_delay;
  logic [7:0]    r_off;
  logic          r_ready;
  logic [8:0]    r_x;
  logic [7:0]    r_y;
  logic [2:0]    r_color;
  logic          r_plot;
  logic          r_frame;

  logic [DW-1:0]     w_delay_nx;
  logic signed [9:0] w_off;
  logic signed [9:0] w_diff;
  logic [7:0]        w_y_tgt;
  logic              w_unused_sample;

  // Only the sign bit and the low seven magnitude bits set the trace offset.
  assign w_unused_sample = ^bus.sample_data[14:7];

  always_comb begin
    w_delay_nx = (r_delay == HOLD) ? HOLD : r_delay + DW'(1);
    w_off      = {{2{r_off[7]}}, r_off};
    w_diff     = YMID_S - w_off;
    if (w_diff < 10'sd0)
      w_y_tgt = '0;
    else if (w_diff > YMAX_S)
      w_y_tgt = YM;
    else
      w_y_tgt = w_diff[7:0];
  end

`ifdef TRACE_CONNECT_EN
  logic [7:0] r_y_prev;
  logic [7:0] w_lo;
  logic [7:0] w_hi;

  always_comb begin
    w_lo = (r_y_prev < w_y_tgt) ? r_y_prev : w_y_tgt;
    w_hi = (r_y_prev < w_y_tgt) ? w_y_tgt : r_y_prev;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_WAIT;
      r_delay <= '0;
      r_off   <= '0;
      r_ready <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= COLOR_BG;
      r_plot  <= 1'b0;
      r_frame <= 1'b0;
`ifdef TRACE_CONNECT_EN
      r_y_prev <= 8'(Y_MID);
`endif
    end else begin
      r_frame <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (bus.sample_valid && r_ready) begin
            r_off   <= {bus.sample_data[15], bus.sample_data[6:0]};
            r_state <= S_CLEAR;
            r_delay <= '0;
            r_ready <= 1'b0;
            r_y     <= '0;
            r_color <= COLOR_BG;
            r_plot  <= 1'b1;
          end else begin
            // ready is registered, so it is derived from the delay value of the coming cycle
            r_delay <= w_delay_nx;
            r_ready <= (w_delay_nx == HOLD) && !pause;
          end
        end
        S_CLEAR: begin
          if (r_y == YM) begin
            r_state <= S_DRAW;
            r_color <= COLOR_FG;
`ifdef TRACE_CONNECT_EN
            r_y <= w_lo;
`else
            r_y <= w_y_tgt;
`endif
          end else begin
            r_y <= r_y + 8'd1;
          end
        end
        S_DRAW: begin
`ifdef TRACE_CONNECT_EN
          if (r_y != w_hi) begin
            r_y <= r_y + 8'd1;
          end else
`endif
          begin
            r_state <= S_ADVANCE;
            r_plot  <= 1'b0;
            if (r_x == XM) begin
              r_x     <= '0;
              r_frame <= 1'b1;
            end else begin
              r_x <= r_x + 9'd1;
            end
          end
        end
        S_ADVANCE: begin
          r_state <= S_WAIT;
          r_delay <= '0;
          r_ready <= (HOLD_CYCLES == 0) && !pause;
`ifdef TRACE_CONNECT_EN
          r_y_prev <= w_y_tgt;
`endif
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign bus.sample_ready = r_ready;
  assign bus.x_coords     = r_x;
  assign bus.y_coords     = r_y;
  assign bus.color_on_vga = r_color;
  assign bus.plot_on_vga  = r_plot;
  assign bus.frame_done   = r_frame;

endmodule
